axi_lite_seq_master: RTL and testbench

Synthesizable AXI4-Lite master that performs the sequential write-then-readback register exercise in hardware. It writes a block of consecutive words to a slave, such as the ADS SPI controller's S00_AXI register bank, then reads the same words back and compares each one. It sits on the slave's AXI4-Lite port, either in place of the PS interconnect for board bring-up or in a loopback self-test design. It reports busy, done, pass and an error count.

---
 rtl/axi_lite_seq_master.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_axi_lite_seq_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_seq_master.sv
// axi_lite_seq_master
// AXI4-Lite master that runs a write-then-readback exercise against a slave.
// It writes C_NUM_WORDS consecutive words (C_SEED + i at C_BASE_ADDR + 4*i),
// then reads every word back and compares it. It reports busy, done, pass and
// a saturating error count.
// Optional feature: define AXI_SEQ_MASTER_TIMEOUT_EN to build a stall watchdog
// that abandons the run after C_TIMEOUT_CYCLES waiting cycles and raises timeout.
module axi_lite_seq_master #(
  parameter int unsigned                    C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                    C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                    C_NUM_WORDS        = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  C_BASE_ADDR        = 32'h0000_0000,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]  C_SEED             = 32'h0000_0001,
  parameter int unsigned                    C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [7:0]                        error_cnt,
  output logic                              timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    FIN
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(C_NUM_WORDS - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_t                          state, state_nxt;
  logic [7:0]                      idx, idx_nxt;
  logic [7:0]                      err, err_nxt;
  logic                            busy_r, busy_nxt;
  logic                            done_r, done_nxt;
  logic                            awvalid_r, awvalid_nxt;
  logic                            wvalid_r, wvalid_nxt;
  logic                            bready_r, bready_nxt;
  logic                            arvalid_r, arvalid_nxt;
  logic                            rready_r, rready_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r, awaddr_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_r, araddr_nxt;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r, wdata_nxt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Byte address of word i in the target block.
  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr(input logic [7:0] i);
    return C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({i, 2'b00});
  endfunction

  // Pattern written to (and expected back from) word i.
  function automatic logic [C_M_AXI_DATA_WIDTH-1:0] word_data(input logic [7:0] i);
    return C_SEED + C_M_AXI_DATA_WIDTH'(i);
  endfunction

  // Error counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign aw_hs = awvalid_r & m00_axi_awready;
  assign w_hs  = wvalid_r  & m00_axi_wready;
  assign b_hs  = bready_r  & m00_axi_bvalid;
  assign ar_hs = arvalid_r & m00_axi_arready;
  assign r_hs  = rready_r  & m00_axi_rvalid;

`ifdef AXI_SEQ_MASTER_TIMEOUT_EN
  localparam logic [16:0] WD_LIMIT = 17'(C_TIMEOUT_CYCLES);

  logic [15:0] wd_cnt, wd_cnt_nxt;
  logic        timeout_r, timeout_nxt;
  logic        waiting, any_hs, wd_fire;

  // Watchdog: counts consecutive stalled cycles in the bus states, restarts on any handshake.
  always_comb begin
    waiting    = (state == WR_REQ) || (state == WR_RESP) ||
                 (state == RD_REQ) || (state == RD_DATA);
    any_hs     = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    wd_cnt_nxt = '0;
    wd_fire    = 1'b0;
    if (waiting && !any_hs) begin
      wd_cnt_nxt = wd_cnt + 16'd1;
      wd_fire    = (({1'b0, wd_cnt} + 17'd1) == WD_LIMIT);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_fire ? 16'd0 : wd_cnt_nxt;
    end
  end
`endif

  // Next-state and next-output logic for the write/readback sequencer.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    err_nxt     = err;
    busy_nxt    = busy_r;
    done_nxt    = done_r;
    awvalid_nxt = awvalid_r;
    wvalid_nxt  = wvalid_r;
    bready_nxt  = bready_r;
    arvalid_nxt = arvalid_r;
    rready_nxt  = rready_r;
    awaddr_nxt  = awaddr_r;
    wdata_nxt   = wdata_r;
    araddr_nxt  = araddr_r;
`ifdef AXI_SEQ_MASTER_TIMEOUT_EN
    timeout_nxt = timeout_r;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          idx_nxt     = 8'd0;
          err_nxt     = 8'd0;
          done_nxt    = 1'b0;
          busy_nxt    = 1'b1;
`ifdef AXI_SEQ_MASTER_TIMEOUT_EN
          timeout_nxt = 1'b0;
`endif
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          awaddr_nxt  = word_addr(8'd0);
          wdata_nxt   = word_data(8'd0);
          state_nxt   = WR_REQ;
        end
      end

      WR_REQ: begin
        // Address and data channels retire independently; a channel whose
        // valid is already low has finished for this word.
        if (aw_hs) awvalid_nxt = 1'b0;
        if (w_hs)  wvalid_nxt  = 1'b0;
        if ((!awvalid_r || m00_axi_awready) && (!wvalid_r || m00_axi_wready)) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          bready_nxt = 1'b0;
          if (m00_axi_bresp != RESP_OKAY) err_nxt = sat_inc(err);
          if (idx == LAST_IDX) begin
            idx_nxt     = 8'd0;
            arvalid_nxt = 1'b1;
            araddr_nxt  = word_addr(8'd0);
            state_nxt   = RD_REQ;
          end else begin
            idx_nxt     = idx + 8'd1;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            awaddr_nxt  = word_addr(idx + 8'd1);
            wdata_nxt   = word_data(idx + 8'd1);
            state_nxt   = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        if (ar_hs) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (r_hs) begin
          rready_nxt = 1'b0;
          // Bad data and a bad response on the same word count as one error.
          if ((m00_axi_rdata != word_data(idx)) || (m00_axi_rresp != RESP_OKAY)) begin
            err_nxt = sat_inc(err);
          end
          if (idx == LAST_IDX) begin
            state_nxt = FIN;
          end else begin
            idx_nxt     = idx + 8'd1;
            arvalid_nxt = 1'b1;
            araddr_nxt  = word_addr(idx + 8'd1);
            state_nxt   = RD_REQ;
          end
        end
      end

      FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef AXI_SEQ_MASTER_TIMEOUT_EN
    // A stalled slave abandons the run: withdraw every request and finish.
    if (wd_fire) begin
      awvalid_nxt = 1'b0;
      wvalid_nxt  = 1'b0;
      bready_nxt  = 1'b0;
      arvalid_nxt = 1'b0;
      rready_nxt  = 1'b0;
      timeout_nxt = 1'b1;
      state_nxt   = FIN;
    end
`endif
  end

  // State and output registers; reset abandons any run in progress.
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state     <= IDLE;
      idx       <= 8'd0;
      err       <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      araddr_r  <= '0;
`ifdef AXI_SEQ_MASTER_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      err       <= err_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      awvalid_r <= awvalid_nxt;
      wvalid_r  <= wvalid_nxt;
      bready_r  <= bready_nxt;
      arvalid_r <= arvalid_nxt;
      rready_r  <= rready_nxt;
      awaddr_r  <= awaddr_nxt;
      wdata_r   <= wdata_nxt;
      araddr_r  <= araddr_nxt;
`ifdef AXI_SEQ_MASTER_TIMEOUT_EN
      timeout_r <= timeout_nxt;
`endif
    end
  end

`ifdef AXI_SEQ_MASTER_TIMEOUT_EN
  assign timeout = timeout_r;
`else
  // Without the watchdog the limit has no effect; it stays referenced here.
  logic [31:0] unused_timeout_limit;
  assign unused_timeout_limit = 32'(C_TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  assign busy            = busy_r;
  assign done            = done_r;
  assign error_cnt       = err;
  assign pass            = done_r && (err == 8'd0) && !timeout;
  assign m00_axi_awaddr  = awaddr_r;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = awvalid_r;
  assign m00_axi_wdata   = wdata_r;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_wvalid  = wvalid_r;
  assign m00_axi_bready  = bready_r;
  assign m00_axi_araddr  = araddr_r;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = arvalid_r;
  assign m00_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_seq_master.sv
// tb_axi_lite_seq_master
// Self-checking bench: a behavioural AXI4-Lite memory slave with configurable
// stalls and fault injection, plus a write/read-address scoreboard filled at
// each start and drained as the DUT issues transfers.
module tb_axi_lite_seq_master;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass, timeout;
  logic [7:0]  error_cnt;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int passed = 0;

  int cfg_aw_delay;
  bit cfg_aw_stuck;
  int cfg_corrupt_word;
  int cfg_bresp_err_word;
  int cfg_rresp_err_word;
  int aw_beats;
  int w_beats;

  logic [31:0] mem [256];
  logic [31:0] exp_wr_addr [$];
  logic [31:0] exp_wr_data [$];
  logic [31:0] exp_rd_addr [$];

  axi_lite_seq_master #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_NUM_WORDS        (N),
    .C_BASE_ADDR        (BASE),
    .C_SEED             (SEED),
    .C_TIMEOUT_CYCLES   (1024)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_areset  (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_cnt       (error_cnt),
    .timeout         (timeout),
    .m00_axi_awaddr  (awaddr),
    .m00_axi_awprot  (awprot),
    .m00_axi_awvalid (awvalid),
    .m00_axi_awready (awready),
    .m00_axi_wdata   (wdata),
    .m00_axi_wstrb   (wstrb),
    .m00_axi_wvalid  (wvalid),
    .m00_axi_wready  (wready),
    .m00_axi_bresp   (bresp),
    .m00_axi_bvalid  (bvalid),
    .m00_axi_bready  (bready),
    .m00_axi_araddr  (araddr),
    .m00_axi_arprot  (arprot),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  // Slave model: evaluates handshakes of the edge just passed, then drives the next cycle.
  initial begin : slave
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [31:0] lat_awaddr, lat_wdata, ea, ed;
    bit          have_aw, have_w;
    int          aw_wait, word;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; lat_awaddr = '0; lat_wdata = '0;
    have_aw = 1'b0; have_w = 1'b0; aw_wait = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        have_aw = 1'b0; have_w = 1'b0; aw_wait = 0;
      end else begin
        if (bvalid && s_bready) bvalid = 1'b0;
        if (rvalid && s_rready) rvalid = 1'b0;
        if (s_awvalid && awready) begin lat_awaddr = s_awaddr; have_aw = 1'b1; aw_beats++; end
        if (s_wvalid && wready) begin lat_wdata = s_wdata; have_w = 1'b1; w_beats++; end
        if (have_aw && have_w) begin
          word = int'(lat_awaddr[9:2]);
          mem[word] = lat_wdata;
          checks++;
          if (exp_wr_addr.size() == 0) begin
            $display("[TB] FAIL wr_unexpected got addr=%h data=%h expected none", lat_awaddr, lat_wdata);
          end else begin
            ea = exp_wr_addr.pop_front();
            ed = exp_wr_data.pop_front();
            if (lat_awaddr !== ea || lat_wdata !== ed)
              $display("[TB] FAIL wr_beat got addr=%h data=%h expected addr=%h data=%h", lat_awaddr, lat_wdata, ea, ed);
            else passed++;
          end
          bvalid = 1'b1;
          bresp = (word == cfg_bresp_err_word) ? 2'b10 : 2'b00;
          have_aw = 1'b0; have_w = 1'b0;
        end
        if (s_arvalid && arready) begin
          word = int'(s_araddr[9:2]);
          checks++;
          if (exp_rd_addr.size() == 0) begin
            $display("[TB] FAIL rd_unexpected got addr=%h expected none", s_araddr);
          end else begin
            ea = exp_rd_addr.pop_front();
            if (s_araddr !== ea) $display("[TB] FAIL rd_addr got=%h expected=%h", s_araddr, ea);
            else passed++;
          end
          rvalid = 1'b1;
          rdata = (word == cfg_corrupt_word) ? 32'h0000_DEAD : mem[word];
          rresp = (word == cfg_rresp_err_word) ? 2'b10 : 2'b00;
        end
        if (cfg_aw_stuck) begin
          awready = 1'b0;
        end else if (awvalid) begin
          if (aw_wait >= cfg_aw_delay) awready = 1'b1;
          else begin awready = 1'b0; aw_wait++; end
        end else begin
          awready = 1'b0; aw_wait = 0;
        end
        wready  = wvalid;
        arready = arvalid;
      end
      s_awvalid = awvalid; s_wvalid = wvalid; s_bready = bready;
      s_arvalid = arvalid; s_rready = rready;
      s_awaddr = awaddr; s_wdata = wdata; s_araddr = araddr;
    end
  end

  task automatic clear_cfg();
    cfg_aw_delay = 0; cfg_aw_stuck = 1'b0;
    cfg_corrupt_word = -1; cfg_bresp_err_word = -1; cfg_rresp_err_word = -1;
    aw_beats = 0; w_beats = 0;
  endtask

  // Loads the scoreboard for one full run and pulses start across one edge.
  task automatic launch();
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
    for (int i = 0; i < N; i++) begin
      exp_wr_addr.push_back(BASE + 32'(4 * i));
      exp_wr_data.push_back(SEED + 32'(i));
      exp_rd_addr.push_back(BASE + 32'(4 * i));
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) $display("[TB] FAIL rst_handshake got=%b expected=00000", {awvalid, wvalid, bready, arvalid, rready}); else passed++;
    checks++; if ({busy, done, pass, timeout} !== 4'b0) $display("[TB] FAIL rst_status got=%b expected=0000", {busy, done, pass, timeout}); else passed++;
    checks++; if (error_cnt !== 8'd0) $display("[TB] FAIL rst_error_cnt got=%0d expected=0", error_cnt); else passed++;
    checks++; if ({awaddr, wdata, araddr} !== 96'd0) $display("[TB] FAIL rst_addr_data got=%h expected=0", {awaddr, wdata, araddr}); else passed++;
    checks++; if ({awprot, arprot, wstrb} !== 10'b000_000_1111) $display("[TB] FAIL rst_prot_strb got=%b expected=0000001111", {awprot, arprot, wstrb}); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    int cyc;
    clear_cfg();
    launch();
    checks++; if ({awvalid, wvalid, busy} !== 3'b111) $display("[TB] FAIL zw_first_req got=%b expected=111", {awvalid, wvalid, busy}); else passed++;
    checks++; if (awaddr !== BASE || wdata !== SEED) $display("[TB] FAIL zw_first_beat got addr=%h data=%h expected addr=%h data=%h", awaddr, wdata, BASE, SEED); else passed++;
    wait_done(200, cyc);
    checks++; if (cyc !== 17) $display("[TB] FAIL zw_done_latency got=%0d expected=17", cyc); else passed++;
    checks++; if ({done, pass, busy, timeout} !== 4'b1100) $display("[TB] FAIL zw_status got=%b expected=1100", {done, pass, busy, timeout}); else passed++;
    checks++; if (error_cnt !== 8'd0) $display("[TB] FAIL zw_error_cnt got=%0d expected=0", error_cnt); else passed++;
    for (int i = 0; i < N; i++) begin
      checks++; if (mem[i] !== SEED + 32'(i)) $display("[TB] FAIL zw_mem%0d got=%h expected=%h", i, mem[i], SEED + 32'(i)); else passed++;
    end
    checks++; if (exp_wr_addr.size() + exp_rd_addr.size() != 0) $display("[TB] FAIL zw_scoreboard_left got=%0d expected=0", exp_wr_addr.size() + exp_rd_addr.size()); else passed++;
  endtask

  task automatic test_aw_delay();
    int cyc;
    clear_cfg();
    cfg_aw_delay = 3;
    launch();
    checks++; if ({awvalid, wvalid} !== 2'b11) $display("[TB] FAIL awd_rise got=%b expected=11", {awvalid, wvalid}); else passed++;
    @(posedge clk); #1;
    checks++; if ({awvalid, wvalid} !== 2'b10) $display("[TB] FAIL awd_w_dropped got=%b expected=10", {awvalid, wvalid}); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({awvalid, wvalid} !== 2'b10) $display("[TB] FAIL awd_aw_held got=%b expected=10", {awvalid, wvalid}); else passed++;
    @(posedge clk); #1;
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) $display("[TB] FAIL awd_aw_dropped got=%b expected=001", {awvalid, wvalid, bready}); else passed++;
    wait_done(500, cyc);
    checks++; if ({done, pass} !== 2'b11) $display("[TB] FAIL awd_status got=%b expected=11", {done, pass}); else passed++;
    checks++; if (aw_beats != N || w_beats != N) $display("[TB] FAIL awd_beats got aw=%0d w=%0d expected=%0d", aw_beats, w_beats, N); else passed++;
    checks++; if (exp_wr_addr.size() != 0) $display("[TB] FAIL awd_writes_left got=%0d expected=0", exp_wr_addr.size()); else passed++;
  endtask

  task automatic test_corrupt_read();
    int cyc;
    clear_cfg();
    cfg_corrupt_word = 2;
    launch();
    wait_done(200, cyc);
    checks++; if ({done, pass} !== 2'b10) $display("[TB] FAIL corrupt_status got=%b expected=10", {done, pass}); else passed++;
    checks++; if (error_cnt !== 8'd1) $display("[TB] FAIL corrupt_error_cnt got=%0d expected=1", error_cnt); else passed++;
  endtask

  task automatic test_slverr();
    int cyc;
    clear_cfg();
    cfg_bresp_err_word = 0;
    cfg_rresp_err_word = 3;
    cfg_corrupt_word = 3;
    launch();
    wait_done(200, cyc);
    checks++; if ({done, pass} !== 2'b10) $display("[TB] FAIL slverr_status got=%b expected=10", {done, pass}); else passed++;
    checks++; if (error_cnt !== 8'd2) $display("[TB] FAIL slverr_error_cnt got=%0d expected=2", error_cnt); else passed++;
  endtask

  task automatic test_start_ignored();
    clear_cfg();
    launch();
    for (int c = 1; c <= 17; c++) begin
      start = (c == 5 || c == 17);
      @(posedge clk); #1;
      if (c == 16) begin
        checks++; if (done !== 1'b0) $display("[TB] FAIL ign_early_done got=%b expected=0", done); else passed++;
      end
    end
    start = 1'b0;
    checks++; if ({done, busy, pass} !== 3'b101) $display("[TB] FAIL ign_done_at_17 got=%b expected=101", {done, busy, pass}); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, awvalid, done} !== 3'b001) $display("[TB] FAIL ign_no_rerun got=%b expected=001", {busy, awvalid, done}); else passed++;
    checks++; if (aw_beats != N || w_beats != N) $display("[TB] FAIL ign_beats got aw=%0d w=%0d expected=%0d", aw_beats, w_beats, N); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_cfg();
    cfg_corrupt_word = 1;
    launch();
    wait_done(200, cyc);
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({done, error_cnt} !== {1'b1, 8'd1}) $display("[TB] FAIL b2b_done_held got done=%b err=%0d expected done=1 err=1", done, error_cnt); else passed++;
    cfg_corrupt_word = -1;
    launch();
    checks++; if ({done, busy, error_cnt} !== {2'b01, 8'd0}) $display("[TB] FAIL b2b_restart got done=%b busy=%b err=%0d expected done=0 busy=1 err=0", done, busy, error_cnt); else passed++;
    wait_done(200, cyc);
    checks++; if (cyc !== 17 || pass !== 1'b1) $display("[TB] FAIL b2b_second_run got cyc=%0d pass=%b expected cyc=17 pass=1", cyc, pass); else passed++;
  endtask

  task automatic test_no_response();
    int bad;
    clear_cfg();
    cfg_aw_stuck = 1'b1;
    launch();
    bad = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("[TB] FAIL stuck_busy got=%0d idle cycles expected=0", bad); else passed++;
    checks++; if ({awvalid, timeout} !== 2'b10 || w_beats != 1) $display("[TB] FAIL stuck_channels got awvalid=%b timeout=%b wbeats=%0d expected 1 0 1", awvalid, timeout, w_beats); else passed++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cfg_aw_stuck = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    clear_cfg();
    cfg_corrupt_word = 0;
    launch();
    cyc = 0;
    while (!(rready === 1'b1 && error_cnt === 8'd1) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++; if (cyc >= 100) $display("[TB] FAIL mid_reach_rd_data got=%0d cycles expected<100", cyc); else passed++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) $display("[TB] FAIL mid_rst_handshake got=%b expected=00000", {awvalid, wvalid, bready, arvalid, rready}); else passed++;
    checks++; if ({busy, done, error_cnt} !== {2'b00, 8'd0}) $display("[TB] FAIL mid_rst_status got busy=%b done=%b err=%0d expected 0 0 0", busy, done, error_cnt); else passed++;
    @(negedge clk); rst = 1'b0;
    cfg_corrupt_word = -1;
    launch();
    wait_done(200, cyc);
    checks++; if ({done, pass} !== 2'b11 || error_cnt !== 8'd0) $display("[TB] FAIL mid_rerun got done=%b pass=%b err=%0d expected 1 1 0", done, pass, error_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clear_cfg();
    test_reset();
    test_zero_wait();
    test_aw_delay();
    test_corrupt_read();
    test_slverr();
    test_start_ignored();
    test_back_to_back();
    test_no_response();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
